// File: rtl/hazard_track_pipe_if.sv
// hazard_track_pipe_if: ID-side decode/control inputs and EX/MEM/WB tracking outputs
interface hazard_track_pipe_if #(parameter int CNT_W = 16);
  logic [4:0] IDrs, IDrt, IDrd;
  logic IDRegDst, IDJal, IDRegWrite, IDMemRead;
  logic stall, flush, hold;
  logic [4:0] EXrs, EXrt, EXrd, MEMrd, WBrd;
  logic EXRegWrite, EXMemRead, MEMRegWrite, WBRegWrite;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output IDrs, IDrt, IDrd, IDRegDst, IDJal, IDRegWrite, IDMemRead, stall, flush, hold,
    input EXrs, EXrt, EXrd, EXRegWrite, EXMemRead, MEMrd, MEMRegWrite, WBrd, WBRegWrite,
    input stall_cnt, flush_cnt
  );
  modport slave (
    input IDrs, IDrt, IDrd, IDRegDst, IDJal, IDRegWrite, IDMemRead, stall, flush, hold,
    output EXrs, EXrt, EXrd, EXRegWrite, EXMemRead, MEMrd, MEMRegWrite, WBrd, WBRegWrite,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_track_pipe.sv
// hazard_track_pipe: carries register indices and write/read flags ID->EX->MEM->WB for hazard detection
module hazard_track_pipe #(
  parameter int CNT_W = 16,
  parameter logic [4:0] RA_REG = 5'd31
) (
  input logic clk,
  input logic reset,
  hazard_track_pipe_if.slave bus
);
  logic [4:0] dest, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic wr, bubble, ex_wr, ex_mr, mem_wr, wb_wr;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  // resolve destination in ID; writes to r0 are dropped before entering the pipe
  always_comb begin
    dest = bus.IDJal ? RA_REG : (bus.IDRegDst ? bus.IDrd : bus.IDrt);
    wr = bus.IDRegWrite && (dest != 5'd0);
    bubble = bus.stall || bus.flush;
  end
  // ID->EX register: hold freezes, stall/flush load an all-zero bubble
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_rs <= '0;
      ex_rt <= '0;
      ex_rd <= '0;
      ex_wr <= 1'b0;
      ex_mr <= 1'b0;
    end else if (!bus.hold) begin
      ex_rs <= bubble ? 5'd0 : bus.IDrs;
      ex_rt <= bubble ? 5'd0 : bus.IDrt;
      ex_rd <= bubble ? 5'd0 : dest;
      ex_wr <= !bubble && wr;
      ex_mr <= !bubble && bus.IDMemRead;
    end
  // EX->MEM->WB shift, independent of stall/flush
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_rd <= '0;
      mem_wr <= 1'b0;
      wb_rd <= '0;
      wb_wr <= 1'b0;
    end else if (!bus.hold) begin
      mem_rd <= ex_rd;
      mem_wr <= ex_wr;
      wb_rd <= mem_rd;
      wb_wr <= mem_wr;
    end
  // saturating bubble counters; a combined stall+flush counts only as a flush
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!bus.hold) begin
      if (bus.flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      if (bus.stall && !bus.flush && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  assign bus.EXrs = ex_rs;
  assign bus.EXrt = ex_rt;
  assign bus.EXrd = ex_rd;
  assign bus.EXRegWrite = ex_wr;
  assign bus.EXMemRead = ex_mr;
  assign bus.MEMrd = mem_rd;
  assign bus.MEMRegWrite = mem_wr;
  assign bus.WBrd = wb_rd;
  assign bus.WBRegWrite = wb_wr;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
endmodule
